// File: rtl/uart_pkg.sv
// Definitions shared by the 8N1 UART transmitter and receiver: default bit
// period, frame width and the receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_CYCLES_PER_SAMPLE = 21812;
  localparam int unsigned UART_DATA_BITS         = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } RxState;

  // Terminal value of the 24-bit bit-period counter for a given cycle count.
  function automatic logic [23:0] cnt_last(input int unsigned cycles);
    return 24'(cycles - 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to 1 so that reset looks like an idle line.
module uart_rx_sync (
  input  logic clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_rx_s
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_rx;
      sync_q <= meta_q;
    end
  end

  assign o_rx_s = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive end: synchronises the line, samples each bit at mid-period
// and reports every byte as a one-cycle o_valid pulse, or flags a framing error.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SAMPLE = UART_CYCLES_PER_SAMPLE,
  parameter int unsigned HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [0:7] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_busy,
  output RxState     o_state
);

  localparam logic [23:0] HALF_LAST    = cnt_last(HALF_SAMPLE);
  localparam logic [23:0] BIT_LAST     = cnt_last(CYCLES_PER_SAMPLE);
  localparam logic [3:0]  LAST_BIT_IDX = 4'(UART_DATA_BITS - 1);

  logic       rx_s;
  RxState     state_q;
  logic [23:0] cnt_q;
  logic [3:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;

  uart_rx_sync u_sync (
    .clk    (clk),
    .i_reset(i_reset),
    .i_rx   (i_rx),
    .o_rx_s (rx_s)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // A start bit that is high again at mid-period was a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q                   <= '0;
            shift_q[bit_idx_q[2:0]] <= rx_s;
            bit_idx_q               <= bit_idx_q + 4'd1;
            if (bit_idx_q == LAST_BIT_IDX) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit keeps half a bit of margin for a
          // back-to-back start edge.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The first bit on the wire is data_q[0], which lands in o_data[7].
  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != IDLE);
  assign o_state       = state_q;

endmodule
